// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter
//   Round-robin arbiter that gives two requesters alternating ownership of a
//   single RAM. Each granted transaction is one READ cycle followed by one
//   WRITE cycle. If the RAM reports SlowRAM during WRITE, DELAY_CYCLES
//   recovery cycles follow. At least one IDLE cycle separates transactions.
//
// Parameters
//   DELAY_CYCLES : recovery cycles after a slow write (1..15)
//
// Ports
//   Clock    in   system clock, rising edge
//   Reset    in   synchronous active-high reset
//   Req0     in   requester 0 transaction request, held until Done0
//   Req1     in   requester 1 transaction request, held until Done1
//   SlowRAM  in   RAM needs recovery time (only looked at in WRITE)
//   Read     out  RAM read strobe
//   Write    out  RAM write strobe
//   Grant0   out  RAM owned by requester 0
//   Grant1   out  RAM owned by requester 1
//   Done0    out  final-cycle pulse of a requester-0 transaction
//   Done1    out  final-cycle pulse of a requester-1 transaction
//   Busy     out  arbiter not idle
module ram_rr_arbiter #(
  parameter int unsigned DELAY_CYCLES = 1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Req0,
  input  logic Req1,
  input  logic SlowRAM,
  output logic Read,
  output logic Write,
  output logic Grant0,
  output logic Grant1,
  output logic Done0,
  output logic Done1,
  output logic Busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DELAY = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_owner;   // 0: requester 0 owns the RAM, 1: requester 1
  logic        r_last;    // requester served most recently
  logic [3:0]  r_count;

  state_t      w_state_nxt;
  logic        w_owner_nxt;
  logic        w_last_nxt;
  logic [3:0]  w_count_nxt;
  logic        w_done;

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;    // requester 0 wins the first tie
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_count_nxt = r_count;
    case (r_state)
      IDLE: begin
        if (Req0 || Req1) begin
          // Tie goes to whoever was not served last; otherwise the lone requester.
          if (Req0 && Req1) w_owner_nxt = ~r_last;
          else              w_owner_nxt = Req1;
          w_last_nxt  = w_owner_nxt;
          w_state_nxt = READ;
        end
      end
      READ: begin
        w_state_nxt = WRITE;
      end
      WRITE: begin
        if (SlowRAM) begin
          w_state_nxt = DELAY;
          w_count_nxt = 4'(DELAY_CYCLES - 1);
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DELAY: begin
        if (r_count == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_count_nxt = r_count - 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  // Output decode. Done in WRITE depends on SlowRAM because a fast write
  // completes the transaction in that same cycle.
  always_comb begin
    Read   = 1'b0;
    Write  = 1'b0;
    Busy   = 1'b0;
    w_done = 1'b0;
    case (r_state)
      READ: begin
        Read = 1'b1;
        Busy = 1'b1;
      end
      WRITE: begin
        Write  = 1'b1;
        Busy   = 1'b1;
        w_done = ~SlowRAM;
      end
      DELAY: begin
        Busy   = 1'b1;
        w_done = (r_count == '0);
      end
      default: begin
        Read   = 1'b0;
        Write  = 1'b0;
        Busy   = 1'b0;
        w_done = 1'b0;
      end
    endcase
    Grant0 = Busy & ~r_owner;
    Grant1 = Busy &  r_owner;
    Done0  = w_done & ~r_owner;
    Done1  = w_done &  r_owner;
  end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
module tb_ram_rr_arbiter;

  localparam int unsigned DC = 3;

  logic Clock = 1'b0;
  logic Reset, Req0, Req1, SlowRAM;
  logic Read, Write, Grant0, Grant1, Done0, Done1, Busy;

  typedef struct {
    string      tag;
    logic [6:0] v;   // {Read, Write, Grant0, Grant1, Done0, Done1, Busy}
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  ram_rr_arbiter #(.DELAY_CYCLES(DC)) dut (
    .Clock(Clock), .Reset(Reset), .Req0(Req0), .Req1(Req1), .SlowRAM(SlowRAM),
    .Read(Read), .Write(Write), .Grant0(Grant0), .Grant1(Grant1),
    .Done0(Done0), .Done1(Done1), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (rd wr g0 g1 d0 d1 busy)", tag, act, exp);
    end
  endtask

  function automatic logic [6:0] mk(input bit rd, input bit wr, input bit g0, input bit g1,
                                    input bit d0, input bit d1, input bit busy);
    return {rd, wr, g0, g1, d0, d1, busy};
  endfunction

  // Outputs sampled mid-cycle, against the expectation pushed when that
  // cycle's inputs were driven.
  always @(negedge Clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check(e.tag, {Read, Write, Grant0, Grant1, Done0, Done1, Busy}, e.v);
      check("grant_excl", {6'b0, Grant0 & Grant1}, 7'b0);
    end
  end

  // Drive one cycle's inputs and record what the DUT must show in that cycle.
  task automatic cycle(input string tag, input bit rst, input bit r0, input bit r1,
                       input bit slow, input logic [6:0] exp);
    exp_t e;
    Reset = rst; Req0 = r0; Req1 = r1; SlowRAM = slow;
    e.tag = tag; e.v = exp;
    q.push_back(e);
    @(posedge Clock); #1;
  endtask

  // One full transaction starting in READ. SlowRAM is driven to the opposite
  // of the write decision during READ to show it is ignored there.
  task automatic txn(input string tag, input bit own, input bit slow, input bit r0, input bit r1);
    bit g0, g1;
    g0 = ~own; g1 = own;
    cycle({tag, "_read"},  1'b0, r0, r1, ~slow, mk(1, 0, g0, g1, 0, 0, 1));
    cycle({tag, "_write"}, 1'b0, r0, r1, slow,
          mk(0, 1, g0, g1, ~slow & g0, ~slow & g1, 1));
    if (slow) begin
      for (int unsigned i = 0; i < DC; i++) begin
        bit fin;
        fin = (i == DC - 1);
        cycle({tag, "_delay"}, 1'b0, r0, r1, 1'($urandom_range(0, 1)),
              mk(0, 0, g0, g1, fin & g0, fin & g1, 1));
      end
    end
  endtask

  localparam logic [6:0] Z = 7'b0;

  initial begin
    Reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0; SlowRAM = 1'b0;
    @(posedge Clock); #1;

    // Reset beats simultaneous requests
    cycle("rst_prio", 1, 1, 1, 0, Z);
    // Single fast transaction from requester 0
    cycle("idle_r0", 0, 1, 0, 0, Z);
    txn("fast0", 0, 0, 1, 0);
    cycle("post_fast0", 0, 0, 0, 0, Z);

    // Slow transaction from requester 1: 5 grant cycles, Done1 on last delay
    cycle("idle_r1", 0, 0, 1, 0, Z);
    txn("slow1", 1, 1, 0, 1);
    cycle("post_slow1", 0, 0, 0, 0, Z);

    // Both held after reset: grants alternate 0,1,0,1
    cycle("rst2", 1, 0, 0, 0, Z);
    cycle("idle_tie", 0, 1, 1, 0, Z);
    for (int unsigned k = 0; k < 4; k++) begin
      txn("rr", 1'(k & 1), k == 2, 1, 1);
      cycle("rr_gap", 0, k != 3, k != 3, 0, Z);
    end

    // Reset in WRITE of a slow requester-0 transaction, then a tie goes to 0
    cycle("idle_ab", 0, 1, 0, 0, Z);
    cycle("ab_read", 0, 1, 0, 0, mk(1, 0, 1, 0, 0, 0, 1));
    cycle("ab_write", 1, 1, 0, 1, mk(0, 1, 1, 0, 0, 0, 1));
    cycle("ab_after", 0, 1, 1, 0, Z);
    txn("ab_tie", 0, 0, 1, 1);
    cycle("ab_post", 0, 0, 0, 0, Z);

    // Req0 dropped after grant: transaction completes, nothing new starts
    cycle("idle_drop", 0, 1, 0, 0, Z);
    txn("drop0", 0, 0, 0, 0);
    cycle("drop_idle1", 0, 0, 0, 1, Z);
    cycle("drop_idle2", 0, 0, 0, 0, Z);

    // SlowRAM high in READ only, low in WRITE: fast path
    cycle("idle_tog", 0, 0, 1, 1, Z);
    txn("tog1", 1, 0, 0, 1);
    cycle("tog_idle", 0, 0, 0, 1, Z);
    cycle("tog_idle2", 0, 0, 0, 0, Z);

    @(negedge Clock); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
